vending_machine_multi: RTL

- Parametrised successor to the two-product coin FSM.
- Supports N products with per-product prices, four coin denominations and a credit accumulator.
- Adds cancel/refund, an inactivity timeout, and change paid out one coin at a time over a ready/valid handshake to the coin hopper.
- Sits between the coin acceptor front-end (coin_valid pulses) and the product/hopper actuators.
- All amounts are in 5-cent units.

---
 rtl/vending_machine_multi.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/vending_machine_multi.sv
// rtl/vending_machine_multi.sv - multi-product vending controller with credit, refund, timeout and hopper change
module vending_machine_multi #(
    parameter int                             NUM_PRODUCTS   = 4,
    parameter int                             SEL_W          = 2,
    parameter int                             CREDIT_W       = 8,
    parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES       = {8'd30, 8'd25, 8'd20, 8'd15},
    parameter logic [23:0]                    TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic [SEL_W-1:0]    sel,
    input  logic                vend_req,
    input  logic                cancel,
    input  logic                change_ready,
    output logic                dispense,
    output logic [SEL_W-1:0]    dispense_id,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                vend_err,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CREDIT   = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_e;

    localparam logic [1:0] COIN_NICKEL  = 2'b00;
    localparam logic [1:0] COIN_DIME    = 2'b01;
    localparam logic [1:0] COIN_QUARTER = 2'b10;

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] t);
        case (t)
            2'b00:   return CREDIT_W'(1);
            2'b01:   return CREDIT_W'(2);
            2'b10:   return CREDIT_W'(5);
            default: return CREDIT_W'(20);
        endcase
    endfunction

    function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] c);
        if (c >= CREDIT_W'(5)) begin
            return COIN_QUARTER;
        end else if (c >= CREDIT_W'(2)) begin
            return COIN_DIME;
        end else begin
            return COIN_NICKEL;
        end
    endfunction

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [23:0]         tmo_q, tmo_d;
    logic                dispense_q, dispense_d;
    logic [SEL_W-1:0]    dispense_id_q, dispense_id_d;
    logic                change_valid_q, change_valid_d;
    logic [1:0]          change_coin_q, change_coin_d;
    logic                coin_reject_q, coin_reject_d;
    logic                vend_err_q, vend_err_d;
    logic                busy_q, busy_d;

    logic [CREDIT_W-1:0] price;
    logic                sel_ok;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_ovf;
    logic                idle_tick;

    always_comb begin
        price = '0;
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            if (sel == SEL_W'(i)) begin
                price = PRICES[i*CREDIT_W +: CREDIT_W];
            end
        end
    end

    assign sel_ok   = ($unsigned(NUM_PRODUCTS) > 32'(sel));
    assign coin_sum = {1'b0, credit_q} + {1'b0, coin_value(coin_type)};
    assign coin_ovf = coin_sum[CREDIT_W];

    // Only a coin that would actually be credited counts as activity for the timeout.
    assign idle_tick = (state_q == S_CREDIT) && !cancel && !vend_req && !(coin_valid && !coin_ovf);

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        tmo_d         = tmo_q;
        dispense_d    = 1'b0;
        dispense_id_d = '0;
        coin_reject_d = 1'b0;
        vend_err_d    = 1'b0;

        case (state_q)
            S_IDLE, S_CREDIT: begin
                if (cancel && (state_q == S_CREDIT)) begin
                    state_d       = S_CHANGE;
                    coin_reject_d = coin_valid;
                end else if (vend_req) begin
                    coin_reject_d = coin_valid;
                    if (!sel_ok || (credit_q < price)) begin
                        vend_err_d = 1'b1;
                    end else begin
                        state_d       = S_DISPENSE;
                        dispense_d    = 1'b1;
                        dispense_id_d = sel;
                        credit_d      = credit_q - price;
                    end
                end else if (coin_valid) begin
                    if (coin_ovf) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = S_CREDIT;
                        tmo_d    = '0;
                    end
                end

                if (idle_tick && (TIMEOUT_CYCLES != 24'd0)) begin
                    if (tmo_q == TIMEOUT_CYCLES - 24'd1) begin
                        state_d = S_CHANGE;
                    end else begin
                        tmo_d = tmo_q + 24'd1;
                    end
                end
            end
            S_DISPENSE: begin
                coin_reject_d = coin_valid;
                state_d       = (credit_q != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                coin_reject_d = coin_valid;
                if (change_valid_q && change_ready) begin
                    credit_d = credit_q - coin_value(change_coin_q);
                    if (credit_d == '0) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != S_CREDIT) begin
            tmo_d = '0;
        end

        // Outputs are registered, so they are derived from the next state and credit.
        change_valid_d = (state_d == S_CHANGE);
        change_coin_d  = change_valid_d ? greedy_coin(credit_d) : COIN_NICKEL;
        busy_d         = (state_d == S_DISPENSE) || (state_d == S_CHANGE);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            tmo_q          <= '0;
            dispense_q     <= 1'b0;
            dispense_id_q  <= '0;
            change_valid_q <= 1'b0;
            change_coin_q  <= 2'b00;
            coin_reject_q  <= 1'b0;
            vend_err_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            tmo_q          <= tmo_d;
            dispense_q     <= dispense_d;
            dispense_id_q  <= dispense_id_d;
            change_valid_q <= change_valid_d;
            change_coin_q  <= change_coin_d;
            coin_reject_q  <= coin_reject_d;
            vend_err_q     <= vend_err_d;
            busy_q         <= busy_d;
        end
    end

    assign dispense     = dispense_q;
    assign dispense_id  = dispense_id_q;
    assign change_valid = change_valid_q;
    assign change_coin  = change_coin_q;
    assign credit       = credit_q;
    assign coin_reject  = coin_reject_q;
    assign vend_err     = vend_err_q;
    assign busy         = busy_q;

endmodule
